// File: rtl/fmc_arb_pkg.sv
// Shared types for the FMC memory arbiter: access source enum, the tag that
// follows a read through the pipeline, and default widths.
package fmc_arb_pkg;

  localparam int ADDR_W_DEF        = 8;
  localparam int DATA_W_DEF        = 16;
  localparam int NUM_REQ_DEF       = 2;
  localparam int MAX_FMC_BURST_DEF = 4;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_FMC,
    SRC_INT
  } src_t;

  typedef struct packed {
    src_t src;
    int   idx;
  } tag_t;

  localparam tag_t TAG_NONE = '{src: SRC_NONE, idx: 0};

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// above ptr_i, wrapping to the lowest index.
module rr_arbiter #(
  parameter int NumReq = 2,
  parameter int PtrW   = 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [PtrW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    // First pass covers indices >= ptr, second pass the wrapped low indices.
    for (int k = 0; k < NumReq; k++) begin
      if (!found && req_i[k] && (k >= int'(ptr_i))) begin
        gnt_o[k] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int k = 0; k < NumReq; k++) begin
      if (!found && req_i[k]) begin
        gnt_o[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmc_mem_arbiter.sv
// Arbitrates one single-port memory between the FMC port (priority, burst-limited)
// and NumReq round-robin internal requesters. Optional FMC_ARB_STATS_EN adds a stall counter.
module fmc_mem_arbiter
  import fmc_arb_pkg::*;
#(
  parameter int AddrWidth   = ADDR_W_DEF,
  parameter int DataWidth   = DATA_W_DEF,
  parameter int NumReq      = NUM_REQ_DEF,
  parameter int MaxFmcBurst = MAX_FMC_BURST_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          fmc_req_i,
  input  logic                          fmc_we_i,
  input  logic [AddrWidth-1:0]          fmc_addr_i,
  input  logic [DataWidth-1:0]          fmc_wdata_i,
  output logic                          fmc_gnt_o,
  output logic                          fmc_wait_o,
  output logic                          fmc_rvalid_o,
  input  logic [NumReq-1:0]             int_req_i,
  input  logic [NumReq-1:0]             int_we_i,
  input  logic [NumReq*AddrWidth-1:0]   int_addr_i,
  input  logic [NumReq*DataWidth-1:0]   int_wdata_i,
  output logic [NumReq-1:0]             int_gnt_o,
  output logic [NumReq-1:0]             int_rvalid_o,
  output logic [DataWidth-1:0]          rdata_o,
`ifdef FMC_ARB_STATS_EN
  input  logic                          stats_clr_i,
  output logic [15:0]                   fmc_stall_cnt_o,
`endif
  output logic                          mem_en_o,
  output logic                          mem_we_o,
  output logic [AddrWidth-1:0]          mem_addr_o,
  output logic [DataWidth-1:0]          mem_wdata_o,
  input  logic [DataWidth-1:0]          mem_rdata_i
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = $clog2(MaxFmcBurst + 1);

  logic [CntW-1:0]      burst_cnt_q, burst_cnt_d;
  logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
  logic [DataWidth-1:0] mem_wdata_q, mem_wdata_d;
  tag_t                 tag1_q, tag1_d;
  tag_t                 tag2_q, tag2_d;

  logic [NumReq-1:0]    rr_gnt;
  logic [NumReq-1:0]    int_gnt;
  logic                 any_int;
  logic                 burst_full;
  logic                 fmc_gnt;

  rr_arbiter #(
    .NumReq (NumReq),
    .PtrW   (PtrW)
  ) u_rr_arbiter (
    .req_i  (int_req_i),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (rr_gnt)
  );

  // Grant logic: FMC wins unless it has used its burst and an internal request waits.
  always_comb begin
    any_int    = |int_req_i;
    burst_full = (burst_cnt_q == CntW'(MaxFmcBurst));
    fmc_gnt    = !rst_i && fmc_req_i && !(burst_full && any_int);
    int_gnt    = (rst_i || fmc_gnt) ? '0 : rr_gnt;
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tag1_d      = TAG_NONE;
    tag2_d      = tag1_q;
    if (fmc_gnt) begin
      mem_en_d    = 1'b1;
      mem_we_d    = fmc_we_i;
      mem_addr_d  = fmc_addr_i;
      mem_wdata_d = fmc_wdata_i;
      if (!fmc_we_i) tag1_d = '{src: SRC_FMC, idx: 0};
      if (!burst_full) burst_cnt_d = burst_cnt_q + CntW'(1);
    end else if (|int_gnt) begin
      burst_cnt_d = '0;
      for (int k = 0; k < NumReq; k++) begin
        if (int_gnt[k]) begin
          mem_en_d    = 1'b1;
          mem_we_d    = int_we_i[k];
          mem_addr_d  = int_addr_i[k*AddrWidth +: AddrWidth];
          mem_wdata_d = int_wdata_i[k*DataWidth +: DataWidth];
          rr_ptr_d    = PtrW'((k + 1) % NumReq);
          if (!int_we_i[k]) tag1_d = '{src: SRC_INT, idx: k};
        end
      end
    end else if (!any_int) begin
      burst_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      burst_cnt_q <= '0;
      rr_ptr_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
    end
  end

  always_comb begin
    fmc_gnt_o    = fmc_gnt;
    int_gnt_o    = int_gnt;
    fmc_wait_o   = fmc_req_i && !fmc_gnt && !rst_i;
    fmc_rvalid_o = (tag2_q.src == SRC_FMC);
    for (int k = 0; k < NumReq; k++) begin
      int_rvalid_o[k] = (tag2_q.src == SRC_INT) && (tag2_q.idx == k);
    end
    rdata_o      = mem_rdata_i;
    mem_en_o     = mem_en_q;
    mem_we_o     = mem_we_q;
    mem_addr_o   = mem_addr_q;
    mem_wdata_o  = mem_wdata_q;
  end

`ifdef FMC_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stats_clr_i) begin
      stall_cnt_d = '0;
    end else if (fmc_wait_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign fmc_stall_cnt_o = stall_cnt_q;
`endif

endmodule
